keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Row-scanning controller for the 4x4 matrix keypad that feeds the game's 16-bit `key` bus. It sequences the keypad rows one at a time, samples the columns, assembles a 16-bit frame and debounces whole frames. It publishes a stable key map plus a one-cycle new-press event with the key index. It sits between the board keypad pins and the game logic and replaces raw, bouncy key wiring.

## Interface

Parameters:
- `SCAN_DIV`, default 10_000: clock cycles each row is driven (1 ms at 10 MHz); legal minimum 4.
- `DEBOUNCE_SCANS`, default 20: number of consecutive identical frames required before `key` updates; legal minimum 1.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `en`  in  1: scan enable.
- `col_in`  in  4: keypad columns, active-low (pulled up), asynchronous to `clk`.
- `row_out`  out  4: keypad row drive, active-low, at most one bit low.
- `key`  out  16: debounced key map; bit `r*4+c` = row r, column c; 1 = pressed.
- `key_press`  out  1: one-cycle pulse on a new single-key press.
- `key_code`  out  4: index of the key reported by the last `key_press`.

## Operation

- `col_in` passes through a 2-flop synchronizer. All sampling uses the synchronized value, inverted, so that 1 = pressed.
- State machine:
  - IDLE: `row_out`=4'b1111, slot counter `cnt`=0, `row`=0.
  - SCAN: drive `row_out` = ~(4'b0001<<`row`). `cnt` counts 0..SCAN_DIV-1.
  - At `cnt`==SCAN_DIV-1 (sample cycle), capture the synchronized columns into `frame[row*4 +: 4]`. Then `cnt`←0 and `row`←`row`+1 (wraps 3→0).
- Transitions:
  - IDLE→SCAN when `en`=1.
  - SCAN→IDLE when `en`=0, checked every cycle. A partial frame is discarded and `stable`←0. `key` and `key_code` are held.
- Frame commit happens on the row-3 sample cycle. `new` = {row-3 columns, `frame[11:0]`}.
  - If `new`==`cand`: `stable` increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: `cand`←`new` and `stable`←1.
- When the commit makes `stable` equal DEBOUNCE_SCANS (the transition into that value, not while it is held there), `key`←`new` on that same edge.
- `key_press` is asserted for the cycle after that edge only when the old `key`==0 and `new` has exactly one bit set. On the same edge, `key_code`←index of that bit.
- The following produce no pulse:
  - multi-key frames;
  - a change from one single key directly to another;
  - any release.
- With DEBOUNCE_SCANS=1, `key` follows every committed frame.
- `stable` width is clog2(DEBOUNCE_SCANS+1). `cnt` width is clog2(SCAN_DIV).

## Timing

- Reset (asynchronous, immediate) sets:
  - `row_out`=4'b1111, `key`=0, `key_press`=0, `key_code`=0;
  - `frame`=0, `cand`=0, `stable`=0;
  - state IDLE.
- First rising edge with `rst`=0 and `en`=1: enter SCAN. `row_out`=4'b1110 for SCAN_DIV cycles, then 1101, 1011, 0111, and repeat.
- Frame period is 4·SCAN_DIV cycles.
- Column synchronizer latency is 2 cycles. Because sampling happens at the last cycle of the slot, SCAN_DIV≥4 guarantees the settled value for the driven row is sampled.
- Press-to-`key` latency for a clean press: between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 frames.
- `key_press` is high for exactly one cycle and coincides with the first cycle of the new `key` value.
- `en` falling: `row_out`=4'b1111 from the next edge.
- `en` rising: scanning restarts at row 0, `cnt`=0, with debounce counting from zero.

## Test plan

All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a 16-cycle frame.

- **Reset and scan order.** Hold `rst` high, then release with `en`=1 and `col_in`=4'hF. Required: `row_out` reads 1111 during reset, then 1110×4, 1101×4, 1011×4, 0111×4, repeating. `key` stays 0 and `key_press` never pulses.
- **Single key.** Pull `col_in[2]` low whenever `row_out`=1101 (key 6). Required: after the 3rd committed frame, `key`=16'h0040, one `key_press` pulse, `key_code`=6. On release, `key`=0 after 3 frames with no pulse.
- **Bounce rejection.** Present key 6 in alternate frames for 10 frames. Required: `key` stays 0 and no `key_press`.
- **Multi-key.** Press key 0 and key 15 together. Required: `key`=16'h8001, no `key_press`, `key_code` unchanged.
- **Enable gating.** Deassert `en` mid-row-2 while key 6 is held, after 2 matching frames. Required: `row_out`=1111 on the next edge and `key` held. After re-enable, `key`=16'h0040 only after 3 new frames.
- **Reset during debounce.** Assert `rst` asynchronously mid-cycle with `stable`=2. Required: all outputs are at reset values immediately, and the debounce restarts after release.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning controller for a 4x4 matrix keypad.
// Drives one row at a time and samples the columns at the end of each row slot.
// Each complete 16-bit frame is debounced, and the result is published as a key map
// plus a one-cycle pulse when a single key is newly pressed.
module keypad_scanner #(
  parameter int SCAN_DIV       = 10_000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] key,
  output logic        key_press,
  output logic [3:0]  key_code
);

  localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STABLE_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, SCAN} scanState_t;

  scanState_t          state, stateNext;
  logic [3:0]          colMeta, colSync;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          row;
  logic [11:0]         frame;      // rows 0..2; row 3 feeds the commit directly
  logic [15:0]         cand;
  logic [STABLE_W-1:0] stable;

  logic                sampleCycle, commitCycle, frameMatch, keyUpdate, singleKey;
  logic [3:0]          colPressed;
  logic [15:0]         newFrame;
  logic [STABLE_W-1:0] stableNext;
  logic [3:0]          newCode;

  // Two-flop synchronizer for the asynchronous, active-low column inputs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colMeta <= 4'hF;
      colSync <= 4'hF;
    end else begin
      colMeta <= col_in;
      colSync <= colMeta;
    end
  end

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic and row drive: only the current row is pulled low while scanning.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    row_out   = 4'b1111;
    case (state)
      IDLE: if (en) stateNext = SCAN;
      SCAN: begin
        row_out = ~(4'b0001 << row);
        if (!en) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Frame assembly and debounce decision for the current cycle.
  always_comb begin
    colPressed  = ~colSync;
    sampleCycle = (state == SCAN) && en && (cnt == CNT_LAST);
    commitCycle = sampleCycle && (row == 2'd3);
    newFrame    = {colPressed, frame};
    frameMatch  = (newFrame == cand);
    if (frameMatch)
      stableNext = (stable == STABLE_MAX) ? STABLE_MAX : stable + STABLE_W'(1);
    else
      stableNext = STABLE_W'(1);
    // Update only when the count arrives at the threshold, not while it is held there.
    keyUpdate = commitCycle && (stableNext == STABLE_MAX) &&
                !(frameMatch && (stable == STABLE_MAX));
    singleKey = (newFrame != 16'd0) && ((newFrame & (newFrame - 16'd1)) == 16'd0);
    newCode   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (newFrame[i]) newCode = 4'(i);
    end
  end

  // Slot counter, row pointer, frame capture, debounce and published outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      row       <= '0;
      frame     <= '0;
      cand      <= '0;
      stable    <= '0;
      key       <= '0;
      key_press <= 1'b0;
      key_code  <= '0;
    end else begin
      key_press <= 1'b0;
      if (state == SCAN && en) begin
        if (sampleCycle) begin
          cnt <= '0;
          row <= row + 2'd1;
          case (row)
            2'd0:    frame[3:0]  <= colPressed;
            2'd1:    frame[7:4]  <= colPressed;
            2'd2:    frame[11:8] <= colPressed;
            default: ;
          endcase
          if (commitCycle) begin
            cand   <= newFrame;
            stable <= stableNext;
            if (keyUpdate) begin
              key <= newFrame;
              if (key == 16'd0 && singleKey) begin
                key_press <= 1'b1;
                key_code  <= newCode;
              end
            end
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        // Idle, or leaving scan: restart at row 0 and drop any partial frame.
        cnt <= '0;
        row <= '0;
        if (state == SCAN) begin
          frame  <= '0;
          stable <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x4 keypad and compares key, key_press and
// key_code with a frame-level reference. That reference counts runs of identical frames.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  colIn;
  logic [3:0]  rowOut;
  logic [15:0] key;
  logic        keyPress;
  logic [3:0]  keyCode;

  logic [15:0] phys;      // physically pressed keys, bit r*4+c

  // Reference state: published values plus the run length of identical frames since enable.
  logic [15:0] mKey, lastFrame;
  logic [3:0]  mCode;
  logic        mPress;
  int          runLen;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .en(en), .col_in(colIn),
    .row_out(rowOut), .key(key), .key_press(keyPress), .key_code(keyCode)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its column to the driven (low) row.
  always_comb begin
    colIn = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!rowOut[r]) colIn = colIn & ~phys[r*4 +: 4];
    end
  end

  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] lowIndex(input logic [15:0] f);
    for (int i = 0; i < 16; i++) begin
      if (f[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  // A completed frame: the key map follows a frame once it has been seen DEB times in a row.
  task automatic modelCommit(input logic [15:0] f);
    if (runLen > 0 && f == lastFrame) runLen++;
    else runLen = 1;
    lastFrame = f;
    mPress = 1'b0;
    if (runLen == DEB) begin
      if (mKey == 16'd0 && $countones(f) == 1) begin
        mPress = 1'b1;
        mCode  = lowIndex(f);
      end
      mKey = f;
    end
  endtask

  task automatic checkOutputs(input bit pulseSlot);
    check("key", key, mKey);
    check("key_press", {15'd0, keyPress}, {15'd0, pulseSlot ? mPress : 1'b0});
    check("key_code", {12'd0, keyCode}, {12'd0, mCode});
  endtask

  task automatic checkIdle();
    logic [3:0] idleRow = 4'b1111;
    check("row_idle", {12'd0, rowOut}, {12'd0, idleRow});
    checkOutputs(1'b0);
  endtask

  // Called at the negedge of the first cycle of a frame (row 0 driven, slot count 0).
  // If stopAt < FRAME, the enable is dropped in that cycle and scanning is restarted afterwards.
  task automatic runFrame(input logic [15:0] m, input int stopAt);
    logic [3:0] expRow;
    phys = m;
    for (int i = 0; i < FRAME; i++) begin
      if (i == stopAt) begin
        en = 1'b0;
        @(negedge clk);
        runLen = 0;
        mPress = 1'b0;
        checkIdle();
        repeat (3) begin
          @(negedge clk);
          checkIdle();
        end
        en = 1'b1;
        @(negedge clk);
        return;
      end
      expRow = ~(4'b0001 << (i / SCAN_DIV));
      check("row_out", {12'd0, rowOut}, {12'd0, expRow});
      checkOutputs(i == 0);
      @(negedge clk);
    end
    modelCommit(m);
  endtask

  initial begin
    logic [15:0] m;
    int          reps;
    int          a;
    int          b;

    mKey = '0; mCode = '0; mPress = 1'b0; runLen = 0; lastFrame = '0;
    phys = '0;
    en   = 1'b1;
    rst  = 1'b1;

    // Reset state, then scan order with no keys.
    repeat (2) begin
      @(negedge clk);
      checkIdle();
    end
    rst = 1'b0;
    @(negedge clk);
    repeat (4) runFrame(16'h0000, FRAME);

    // Single key 6 (row 1, column 2), then release.
    repeat (4) runFrame(16'h0040, FRAME);
    repeat (4) runFrame(16'h0000, FRAME);

    // Bounce: key 6 in alternate frames never settles.
    for (int k = 0; k < 10; k++) runFrame((k % 2 == 0) ? 16'h0040 : 16'h0000, FRAME);
    repeat (3) runFrame(16'h0000, FRAME);

    // Multi-key: keys 0 and 15 together update the map but do not pulse.
    repeat (4) runFrame(16'h8001, FRAME);
    repeat (4) runFrame(16'h0000, FRAME);

    // Enable gating: two matching frames, drop enable mid-row-2, then count from zero again.
    repeat (2) runFrame(16'h0040, FRAME);
    runFrame(16'h0040, 9);
    repeat (4) runFrame(16'h0040, FRAME);

    // Reset during debounce: two matching frames of a new pattern, then async reset mid-cycle.
    repeat (2) runFrame(16'h8001, FRAME);
    phys = 16'h8001;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    mKey = '0; mCode = '0; mPress = 1'b0; runLen = 0;
    checkIdle();
    @(negedge clk);
    checkIdle();
    rst = 1'b0;
    @(negedge clk);
    repeat (4) runFrame(16'h0040, FRAME);

    // Randomized frame sequences with runs of varying length and occasional enable drops.
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0:       m = 16'h0000;
        1:       m = 16'(1) << a;
        2:       m = (16'(1) << a) | (16'(1) << b);
        default: m = 16'($urandom);
      endcase
      reps = $urandom_range(1, 5);
      repeat (reps) runFrame(m, FRAME);
      if ($urandom_range(0, 7) == 0) runFrame(m, $urandom_range(1, FRAME - 1));
    end

    checkOutputs(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
